// File: rtl/ts_serial_deframer_pkg.sv
// rtl/ts_serial_deframer_pkg.sv - shared constants, state encoding and helpers for the TS deframer
package ts_pkg;

  localparam int         TS_PKT_LEN   = 188;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PID_W     = 13;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } ts_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ts_serial_deframer_bit_sampler.sv
// rtl/ts_serial_deframer_bit_sampler.sv - oversampling front end: synchronizers, ts_clk fall detect, MSB-first shifter
module ts_bit_sampler (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ts_clk,
  input  logic       i_ts_valid,
  input  logic       i_ts_sync,
  input  logic       i_ts_d0,
  input  logic       i_hunt,
  output logic [7:0] o_byte,
  output logic       o_byte_done,
  output logic       o_sync_at_msb
);

  logic [2:0] r_clk_sync;
  logic [1:0] r_valid_sync;
  logic [1:0] r_sync_sync;
  logic [1:0] r_d0_sync;
  logic [6:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_msb_sync;
  logic       w_sample;
  logic       w_realign;

  // ts_clk gets one extra stage so its fall lines up with the 2-stage data path
  assign w_sample    = r_clk_sync[2] & ~r_clk_sync[1] & r_valid_sync[1];
  assign w_realign   = w_sample & i_hunt & r_sync_sync[1];
  assign o_byte      = {r_shift, r_d0_sync[1]};
  assign o_byte_done = w_sample & ~w_realign & (r_bit_cnt == 3'd7);
  assign o_sync_at_msb = r_msb_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync   <= '0;
      r_valid_sync <= '0;
      r_sync_sync  <= '0;
      r_d0_sync    <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_msb_sync   <= 1'b0;
    end else begin
      r_clk_sync   <= {r_clk_sync[1:0], i_ts_clk};
      r_valid_sync <= {r_valid_sync[0], i_ts_valid};
      r_sync_sync  <= {r_sync_sync[0], i_ts_sync};
      r_d0_sync    <= {r_d0_sync[0], i_ts_d0};
      if (w_sample) begin
        r_shift <= {r_shift[5:0], r_d0_sync[1]};
        if (w_realign) begin
          r_bit_cnt  <= 3'd1;
          r_msb_sync <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd0)
            r_msb_sync <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ts_serial_deframer.sv
// rtl/ts_serial_deframer.sv - serial MPEG-TS deframer with 188-byte packet lock; TS_PID_FILTER_EN adds PID filtering
module ts_serial_deframer
  import ts_pkg::*;
#(
  parameter int         PKT_LEN    = TS_PKT_LEN,
  parameter logic [7:0] SYNC_BYTE  = TS_SYNC_BYTE,
  parameter int         LOCK_CNT   = 3,
  parameter int         UNLOCK_CNT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ts_clk,
  input  logic        i_ts_valid,
  input  logic        i_ts_sync,
  input  logic        i_ts_d0,
`ifdef TS_PID_FILTER_EN
  input  logic [TS_PID_W-1:0] i_pid_sel,
  input  logic        i_pid_filt_on,
`endif
  output logic [7:0]  o_out_data,
  output logic        o_out_valid,
  output logic        o_out_sop,
  output logic        o_out_eop,
  output logic        o_locked,
  output logic [15:0] o_pkt_cnt,
  output logic [15:0] o_err_cnt
);

  localparam int CNT_W  = $clog2(PKT_LEN);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

  ts_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_byte_cnt, w_byte_cnt_nxt, w_cnt_inc;
  logic [GOOD_W-1:0] r_good, w_good_nxt;
  logic [MISS_W-1:0] r_miss, w_miss_nxt;
  logic [7:0]        w_byte;
  logic              w_byte_done, w_sync_at_msb, w_sync_ok, w_at_sop, w_at_eop;
  logic              w_emit, w_err_inc;
  logic [7:0]        w_out_data;
  logic              w_out_valid, w_out_sop, w_out_eop;
  logic [7:0]        r_out_data;
  logic              r_out_valid, r_out_sop, r_out_eop;
  logic [15:0]       r_pkt_cnt, r_err_cnt;

  ts_bit_sampler u_sampler (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_ts_clk      (i_ts_clk),
    .i_ts_valid    (i_ts_valid),
    .i_ts_sync     (i_ts_sync),
    .i_ts_d0       (i_ts_d0),
    .i_hunt        (r_state == HUNT),
    .o_byte        (w_byte),
    .o_byte_done   (w_byte_done),
    .o_sync_at_msb (w_sync_at_msb)
  );

  assign w_sync_ok = (w_byte == SYNC_BYTE);
  assign w_at_sop  = (r_byte_cnt == '0);
  assign w_at_eop  = (r_byte_cnt == CNT_W'(PKT_LEN - 1));
  assign w_cnt_inc = w_at_eop ? '0 : r_byte_cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= HUNT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    w_good_nxt     = r_good;
    w_miss_nxt     = r_miss;
    w_emit         = 1'b0;
    w_err_inc      = 1'b0;
    if (w_byte_done) begin
      case (r_state)
        HUNT: begin
          if (w_sync_at_msb && w_sync_ok) begin
            w_state_nxt    = VERIFY;
            w_byte_cnt_nxt = CNT_W'(1);
            w_good_nxt     = GOOD_W'(1);
          end
        end
        VERIFY: begin
          w_byte_cnt_nxt = w_cnt_inc;
          if (w_at_sop) begin
            if (!w_sync_ok) begin
              w_state_nxt = HUNT;
              w_good_nxt  = '0;
            end else if (r_good + 1'b1 == GOOD_W'(LOCK_CNT)) begin
              // the sync byte that completes lock opens the first delivered packet
              w_state_nxt = LOCKED;
              w_miss_nxt  = '0;
              w_emit      = 1'b1;
            end else begin
              w_good_nxt = r_good + 1'b1;
            end
          end
        end
        LOCKED: begin
          w_byte_cnt_nxt = w_cnt_inc;
          w_emit         = 1'b1;
          if (w_at_sop) begin
            if (w_sync_ok) begin
              w_miss_nxt = '0;
            end else begin
              w_err_inc  = 1'b1;
              w_miss_nxt = r_miss + 1'b1;
              if (r_miss + 1'b1 == MISS_W'(UNLOCK_CNT)) begin
                w_state_nxt = HUNT;
                w_emit      = 1'b0;
                w_good_nxt  = '0;
                w_miss_nxt  = '0;
              end
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

`ifdef TS_PID_FILTER_EN
  logic [2:0][7:0]     r_dl_data;
  logic [2:0]          r_dl_sop, r_dl_eop, r_dl_vld;
  logic [4:0]          r_pid_hi;
  logic [TS_PID_W-1:0] r_pid_sel;
  logic                r_pass_new, r_pass_cur, w_pass_out;

  // a sop leaving the line belongs to the packet whose PID was just resolved at byte 2
  assign w_pass_out  = r_dl_sop[2] ? r_pass_new : r_pass_cur;
  assign w_out_valid = w_emit & r_dl_vld[2] & w_pass_out;
  assign w_out_data  = r_dl_data[2];
  assign w_out_sop   = r_dl_sop[2];
  assign w_out_eop   = r_dl_eop[2];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dl_data  <= '0;
      r_dl_sop   <= '0;
      r_dl_eop   <= '0;
      r_dl_vld   <= '0;
      r_pid_hi   <= '0;
      r_pid_sel  <= '0;
      r_pass_new <= 1'b0;
      r_pass_cur <= 1'b0;
    end else if (w_state_nxt != LOCKED) begin
      r_dl_vld <= '0;
    end else if (w_emit) begin
      r_dl_data  <= {r_dl_data[1:0], w_byte};
      r_dl_sop   <= {r_dl_sop[1:0], w_at_sop};
      r_dl_eop   <= {r_dl_eop[1:0], w_at_eop};
      r_dl_vld   <= {r_dl_vld[1:0], 1'b1};
      r_pass_cur <= w_pass_out;
      if (w_at_sop)
        r_pid_sel <= i_pid_sel;
      if (r_byte_cnt == CNT_W'(1))
        r_pid_hi <= w_byte[4:0];
      if (r_byte_cnt == CNT_W'(2))
        r_pass_new <= !i_pid_filt_on || ({r_pid_hi, w_byte} == r_pid_sel);
    end
  end
`else
  assign w_out_valid = w_emit;
  assign w_out_data  = w_byte;
  assign w_out_sop   = w_at_sop;
  assign w_out_eop   = w_at_eop;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_byte_cnt  <= '0;
      r_good      <= '0;
      r_miss      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_pkt_cnt   <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_good      <= w_good_nxt;
      r_miss      <= w_miss_nxt;
      r_out_valid <= w_out_valid;
      r_out_sop   <= w_out_valid & w_out_sop;
      r_out_eop   <= w_out_valid & w_out_eop;
      if (w_out_valid)
        r_out_data <= w_out_data;
      if (w_out_valid && w_out_eop)
        r_pkt_cnt <= sat_inc16(r_pkt_cnt);
      if (w_err_inc)
        r_err_cnt <= sat_inc16(r_err_cnt);
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_sop   = r_out_sop;
  assign o_out_eop   = r_out_eop;
  assign o_locked    = (r_state == LOCKED);
  assign o_pkt_cnt   = r_pkt_cnt;
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_ts_serial_deframer.sv
// tb/tb_ts_serial_deframer.sv - randomized bench for ts_serial_deframer against a packet-level reference model
module tb_ts_serial_deframer;

  localparam int PKT  = 188;
  localparam int HALF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ts_clk = 1'b0, ts_valid = 1'b0, ts_sync = 1'b0, ts_d0 = 1'b0;
  logic [7:0]  o_out_data;
  logic        o_out_valid, o_out_sop, o_out_eop, o_locked;
  logic [15:0] o_pkt_cnt, o_err_cnt;

  always #5 clk = ~clk;

  ts_serial_deframer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_ts_clk    (ts_clk),
    .i_ts_valid  (ts_valid),
    .i_ts_sync   (ts_sync),
    .i_ts_d0     (ts_d0),
`ifdef TS_PID_FILTER_EN
    .i_pid_sel     (13'h000),
    .i_pid_filt_on (1'b0),
`endif
    .o_out_data  (o_out_data),
    .o_out_valid (o_out_valid),
    .o_out_sop   (o_out_sop),
    .o_out_eop   (o_out_eop),
    .o_locked    (o_locked),
    .o_pkt_cnt   (o_pkt_cnt),
    .o_err_cnt   (o_err_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Packet-level model: each packet is judged by its first byte only.
  typedef enum {M_HUNT, M_VERIFY, M_LOCKED} m_state_e;
  m_state_e   m_state;
  int         m_good, m_miss, m_pkt, m_err;
  logic [9:0] exp_q[$];
  logic [7:0] pkt [PKT];

  task automatic model_reset();
    m_state = M_HUNT;
    m_good = 0; m_miss = 0; m_pkt = 0; m_err = 0;
    exp_q.delete();
  endtask

  task automatic model_packet();
    bit emit = 0;
    case (m_state)
      M_HUNT:   if (pkt[0] == 8'h47) begin m_state = M_VERIFY; m_good = 1; end
      M_VERIFY: begin
        if (pkt[0] != 8'h47) begin m_state = M_HUNT; m_good = 0; end
        else begin
          m_good++;
          if (m_good == 3) begin m_state = M_LOCKED; m_miss = 0; emit = 1; end
        end
      end
      default: begin
        if (pkt[0] == 8'h47) begin m_miss = 0; emit = 1; end
        else begin
          m_err++; m_miss++;
          if (m_miss == 2) m_state = M_HUNT; else emit = 1;
        end
      end
    endcase
    if (emit) begin
      for (int i = 0; i < PKT; i++)
        exp_q.push_back({pkt[i], (i == 0), (i == PKT - 1)});
      m_pkt++;
    end
  endtask

  task automatic make_packet(input logic [7:0] sync);
    pkt[0] = sync;
    for (int i = 1; i < PKT; i++) pkt[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic send_bit(input logic b, input logic s, input logic v);
    ts_d0 = b; ts_sync = s; ts_valid = v; ts_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    ts_clk = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_packet(input int gap_byte, input int stop_byte);
    for (int i = 0; i < PKT; i++) begin
      for (int b = 7; b >= 0; b--) begin
        if (i == stop_byte && b == 3) return;
        if (i == gap_byte && b == 3)
          repeat (20) send_bit(1'($urandom), 1'b0, 1'b0);
        send_bit(pkt[i][b], (i == 0 && b == 7), 1'b1);
      end
    end
    ts_valid = 1'b0; ts_sync = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_locked"}, 32'(o_locked), 32'(m_state == M_LOCKED));
    check_eq({tag, "_pkt_cnt"}, 32'(o_pkt_cnt), 32'(m_pkt));
    check_eq({tag, "_err_cnt"}, 32'(o_err_cnt), 32'(m_err));
    check_eq({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_data"}, 32'(o_out_data), 32'd0);
    check_eq({tag, "_flags"}, 32'({o_out_valid, o_out_sop, o_out_eop, o_locked}), 32'd0);
    check_eq({tag, "_pkt_cnt"}, 32'(o_pkt_cnt), 32'd0);
    check_eq({tag, "_err_cnt"}, 32'(o_err_cnt), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && o_out_valid) begin
      check_eq("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
      check_eq("strobe_locked", 32'(o_locked), 32'd1);
      if (exp_q.size() > 0)
        check_eq("strobe_byte", 32'({o_out_data, o_out_sop, o_out_eop}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    model_reset();
    repeat (4) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // VERIFY interrupted by a bad third sync
    for (int p = 1; p <= 3; p++) begin
      if (p == 3) begin
        do s = 8'($urandom_range(0, 255)); while (s == 8'h47);
      end else s = 8'h47;
      make_packet(s);
      model_packet();
      send_packet(-1, -1);
      check_status("verify");
    end
    check_eq("verify_abort_err", 32'(o_err_cnt), 32'd0);

    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);

    // lock, single miss, double miss, relock, reset mid-packet
    for (int p = 1; p <= 10; p++) begin
      if (p == 6) s = 8'h46;
      else if (p == 7) begin
        do s = 8'($urandom_range(0, 255)); while (s == 8'h47);
      end else s = 8'h47;
      make_packet(s);
      model_packet();
      send_packet((p == 5) ? int'($urandom_range(10, 170)) : -1, (p == 10) ? 100 : -1);
      if (p < 10) check_status($sformatf("pkt%0d", p));
      if (p == 5) check_eq("lock_pkt_cnt", 32'(o_pkt_cnt), 32'd3);
      if (p == 6) check_eq("miss1_locked", 32'({o_locked, o_err_cnt}), 32'h1_0001);
      if (p == 7) check_eq("miss2_unlock", 32'({o_locked, o_err_cnt}), 32'h0_0002);
    end
    check_eq("relock_locked", 32'(o_locked), 32'd1);

    @(negedge clk) rst_n = 1'b0;
    #1;
    check_all_zero("midpkt_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (40) @(negedge clk);
    check_status("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
